// File: rtl/id_unit.sv
// ---------------------------------------------------------------------------
// id_unit
//   16-bit, 16-function operation unit for the rk16 execute path.
//   Each rising clk edge (rst low) captures f(sel, a, b) into the output
//   registers; the result, its zero flag and the carry/borrow flag appear one
//   cycle later and hold until the next edge.
//
// Ports
//   clk    in   1   system clock, rising-edge active
//   rst    in   1   asynchronous, active-high reset (out=0, zero=0, carry=0)
//   sel    in   4   function select
//                     0 ADD   1 SUB   2 AND   3 OR    4 XOR   5 NOT
//                     6 SLL   7 SRL   8 SRA   9 ROL   A ROR   B SLT
//                     C SLTU  D EQ    E PASSA F PASSB
//   a      in   16  operand A
//   b      in   16  operand B; b[3:0] is the shift/rotate amount
//   out    out  16  registered result
//   zero   out  1   registered: result of the captured op == 16'h0000
//   carry  out  1   registered: ADD carry-out / SUB borrow, else 0
//
// There is no handshake: the unit accepts a new operation on every edge.
// ---------------------------------------------------------------------------
module id_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sel,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        zero,
  output logic        carry
);

  // Function codes
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SLL   = 4'h6;
  localparam logic [3:0] OP_SRL   = 4'h7;
  localparam logic [3:0] OP_SRA   = 4'h8;
  localparam logic [3:0] OP_ROL   = 4'h9;
  localparam logic [3:0] OP_ROR   = 4'hA;
  localparam logic [3:0] OP_SLT   = 4'hB;
  localparam logic [3:0] OP_SLTU  = 4'hC;
  localparam logic [3:0] OP_EQ    = 4'hD;
  localparam logic [3:0] OP_PASSA = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  // ------------------------------------------------------------------------
  // Per-function datapath
  // ------------------------------------------------------------------------
  logic [3:0]  w_shamt;
  logic [16:0] w_sum;
  logic [16:0] w_diff;
  logic [15:0] w_sll;
  logic [15:0] w_srl;
  logic [15:0] w_sra;
  logic [31:0] w_dbl_l;
  logic [31:0] w_dbl_r;
  logic [15:0] w_rol;
  logic [15:0] w_ror;
  logic        w_lt_s;
  logic        w_lt_u;
  logic        w_eq;

  // Only the low nibble of b is a shift/rotate amount; b[15:4] is ignored.
  assign w_shamt = b[3:0];

  // 17-bit add: bit 16 is the carry-out.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  // 17-bit subtract of zero-extended operands: bit 16 is set exactly when
  // a < b (unsigned), i.e. it is the borrow.
  assign w_diff = {1'b0, a} - {1'b0, b};

  assign w_sll = a << w_shamt;
  assign w_srl = a >> w_shamt;
  assign w_sra = $signed(a) >>> w_shamt;

  // Rotates via a doubled operand: shifting {a,a} leaves the rotated word
  // in the upper half (left) or lower half (right). Amount 0 yields a.
  assign w_dbl_l = {a, a} << w_shamt;
  assign w_dbl_r = {a, a} >> w_shamt;
  assign w_rol   = w_dbl_l[31:16];
  assign w_ror   = w_dbl_r[15:0];

  assign w_lt_s = $signed(a) < $signed(b);
  assign w_lt_u = w_diff[16];
  assign w_eq   = (a == b);

  // ------------------------------------------------------------------------
  // Function select. Every code is defined; carry is 0 outside ADD/SUB.
  // ------------------------------------------------------------------------
  logic [15:0] w_result;
  logic        w_carry;
  logic        w_zero;

  always_comb begin
    w_result = 16'h0000;
    w_carry  = 1'b0;
    case (sel)
      OP_ADD: begin
        w_result = w_sum[15:0];
        w_carry  = w_sum[16];
      end
      OP_SUB: begin
        w_result = w_diff[15:0];
        w_carry  = w_diff[16];
      end
      OP_AND:   w_result = a & b;
      OP_OR:    w_result = a | b;
      OP_XOR:   w_result = a ^ b;
      OP_NOT:   w_result = ~a;
      OP_SLL:   w_result = w_sll;
      OP_SRL:   w_result = w_srl;
      OP_SRA:   w_result = w_sra;
      OP_ROL:   w_result = w_rol;
      OP_ROR:   w_result = w_ror;
      OP_SLT:   w_result = {15'b0, w_lt_s};
      OP_SLTU:  w_result = {15'b0, w_lt_u};
      OP_EQ:    w_result = {15'b0, w_eq};
      OP_PASSA: w_result = a;
      OP_PASSB: w_result = b;
      default: begin
        w_result = 16'h0000;
        w_carry  = 1'b0;
      end
    endcase
  end

  // zero is derived from the very value being registered into out.
  assign w_zero = (w_result == 16'h0000);

  // ------------------------------------------------------------------------
  // Output registers. Reset clears everything, including zero (even though
  // out reads 0000 during reset), and discards whatever was in flight.
  // ------------------------------------------------------------------------
  logic [15:0] r_out;
  logic        r_zero;
  logic        r_carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= 16'h0000;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      r_out   <= w_result;
      r_zero  <= w_zero;
      r_carry <= w_carry;
    end
  end

  assign out   = r_out;
  assign zero  = r_zero;
  assign carry = r_carry;

endmodule

// File: tb/tb_id_unit.sv
module tb_id_unit;

  // ------------------------------------------------------------------------
  // Clock / reset
  // ------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        zero;
  logic        carry;

  always #5 clk = ~clk;

  id_unit dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .out   (out),
    .zero  (zero),
    .carry (carry)
  );

  int total = 0;
  int bad   = 0;

  // Last captured expectation, used to check that outputs hold between edges.
  logic [15:0] prev_out;
  logic        prev_zero;
  logic        prev_carry;
  bit          have_prev = 1'b0;

  // ------------------------------------------------------------------------
  // Reference model: integer arithmetic, one bit-step at a time for shifts.
  // ------------------------------------------------------------------------
  task automatic model(input logic [3:0] s, input logic [15:0] x,
                       input logic [15:0] y, output logic [15:0] r,
                       output logic c);
    int ux, uy, n, v, sx, sy;
    ux = int'(x);
    uy = int'(y);
    n  = uy % 16;
    v  = 0;
    c  = 1'b0;
    case (s)
      4'h0: begin v = ux + uy; c = (v > 65535); v = v % 65536; end
      4'h1: begin v = (ux - uy + 65536) % 65536; c = (ux < uy); end
      4'h2: v = int'(x & y);
      4'h3: v = int'(x | y);
      4'h4: v = int'(x ^ y);
      4'h5: v = 65535 - ux;
      4'h6: begin v = ux; repeat (n) v = (v * 2) % 65536; end
      4'h7: begin v = ux; repeat (n) v = v / 2; end
      4'h8: begin v = ux; repeat (n) v = v / 2 + ((v >= 32768) ? 32768 : 0); end
      4'h9: begin v = ux; repeat (n) v = (v * 2) % 65536 + v / 32768; end
      4'hA: begin v = ux; repeat (n) v = v / 2 + (v % 2) * 32768; end
      4'hB: begin
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        v  = (sx < sy) ? 1 : 0;
      end
      4'hC: v = (ux < uy) ? 1 : 0;
      4'hD: v = (ux == uy) ? 1 : 0;
      4'hE: v = ux;
      default: v = uy;
    endcase
    r = v[15:0];
  endtask

  // ------------------------------------------------------------------------
  // Comparison point
  // ------------------------------------------------------------------------
  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h expected=%h (sel=%h a=%h b=%h)",
             tag, got, exp, sel, a, b);
    end
  endtask

  // ------------------------------------------------------------------------
  // Driver: present an op at negedge, check the result after the next edge.
  // Also confirms the previous result is still held mid-cycle.
  // ------------------------------------------------------------------------
  task automatic step(input logic [3:0] s, input logic [15:0] x,
                      input logic [15:0] y, input string tag);
    logic [15:0] e_out;
    logic        e_c;
    @(negedge clk);
    sel = s; a = x; b = y;
    #1;
    if (have_prev) begin
      check({tag, ":hold_out"},   out,          prev_out);
      check({tag, ":hold_zero"},  {15'b0, zero},  {15'b0, prev_zero});
      check({tag, ":hold_carry"}, {15'b0, carry}, {15'b0, prev_carry});
    end
    model(s, x, y, e_out, e_c);
    @(posedge clk);
    #1;
    check({tag, ":out"},   out,            e_out);
    check({tag, ":zero"},  {15'b0, zero},  {15'b0, (e_out == 16'h0000)});
    check({tag, ":carry"}, {15'b0, carry}, {15'b0, e_c});
    prev_out   = e_out;
    prev_zero  = (e_out == 16'h0000);
    prev_carry = e_c;
    have_prev  = 1'b1;
  endtask

  // Directed step with literal expected values from the hand-worked cases.
  task automatic step_exp(input logic [3:0] s, input logic [15:0] x,
                          input logic [15:0] y, input logic [15:0] e_out,
                          input logic e_zero, input logic e_c,
                          input string tag);
    @(negedge clk);
    sel = s; a = x; b = y;
    @(posedge clk);
    #1;
    check({tag, ":out"},   out,            e_out);
    check({tag, ":zero"},  {15'b0, zero},  {15'b0, e_zero});
    check({tag, ":carry"}, {15'b0, carry}, {15'b0, e_c});
    prev_out   = e_out;
    prev_zero  = e_zero;
    prev_carry = e_c;
    have_prev  = 1'b1;
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------------
  logic [15:0] pat_a [5];
  logic [15:0] pat_b [5];

  initial begin
    pat_a = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h1234};
    pat_b = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h5678};

    // Reset state, held across edges with live inputs present
    rst = 1'b1; sel = 4'h0; a = 16'h1111; b = 16'h2222;
    #2;
    check("reset:out",   out,            16'h0000);
    check("reset:zero",  {15'b0, zero},  16'h0000);
    check("reset:carry", {15'b0, carry}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold:out",  out,           16'h0000);
    check("reset_hold:zero", {15'b0, zero}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Hand-worked cases
    step_exp(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, "add_wrap");
    step_exp(4'h1, 16'h1234, 16'h5678, 16'hBBBC, 1'b0, 1'b1, "sub_borrow");
    step_exp(4'h6, 16'h1234, 16'h5678, 16'h3400, 1'b0, 1'b0, "sll");
    step_exp(4'h8, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "sra");
    step_exp(4'h9, 16'h1234, 16'h0008, 16'h3412, 1'b0, 1'b0, "rol");
    step_exp(4'hB, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 1'b0, "slt");
    step_exp(4'hC, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, "sltu");
    step_exp(4'hD, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b0, "eq");
    step_exp(4'hA, 16'h00F1, 16'h0004, 16'h100F, 1'b0, 1'b0, "ror");
    step_exp(4'h7, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, "srl15");
    step_exp(4'h9, 16'hABCD, 16'hFFF0, 16'hABCD, 1'b0, 1'b0, "rol0");

    // Sweep: every function against the corner-pattern table
    for (int s = 0; s < 16; s++) begin
      for (int p = 0; p < 5; p++) begin
        step(4'(s), pat_a[p], pat_b[p], $sformatf("sweep_s%0h_p%0d", s, p));
      end
    end

    // Mid-stream reset: result in flight is discarded immediately
    step(4'h3, 16'h00F0, 16'h0F00, "pre_reset");
    @(negedge clk);
    sel = 4'h0; a = 16'hFFFF; b = 16'h0003;
    rst = 1'b1;
    #1;
    check("midrst:out",   out,            16'h0000);
    check("midrst:zero",  {15'b0, zero},  16'h0000);
    check("midrst:carry", {15'b0, carry}, 16'h0000);
    @(posedge clk);
    #1;
    check("midrst_hold:out",   out,            16'h0000);
    check("midrst_hold:carry", {15'b0, carry}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    have_prev = 1'b0;
    // First edge after release captures normally
    step(4'h0, 16'hFFFF, 16'h0003, "post_reset_add");

    // Randomized operations, back to back
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom());
      rb = 16'($urandom());
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = 16'hFFFF;
      step(4'($urandom_range(0, 15)), ra, rb, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
